// File: rtl/mm_pkg.sv
// Shared fetch-stage types and constants; PC_READ_OFFSET is also used by
// register_file and execute for R15 semantics.
package mm_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1
    } fetch_state_t;

    localparam int INSTR_BYTES    = 4;
    localparam int PC_READ_OFFSET = 8;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: architectural PC, req/ack fetch from instruction memory and a
// single-entry instruction buffer for decode, with branch redirect and flush.
module instr_fetch
    import mm_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus8
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_pending;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [ADDR_W-1:0] r_pc_plus8;

    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_fire;
    logic [ADDR_W-1:0] w_target;

    assign w_target = branch_target & ~ADDR_W'(3);
    assign w_fire   = w_req && imem_ack;

    // A raised request keeps its address until acked, whatever stall or
    // branch_valid do; FLUSH only exists to swallow that stale ack.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_pc;
        case (r_state)
            FETCH: begin
                w_req  = rst_n && (r_pending || (!branch_valid && (!r_valid || !stall)));
                w_addr = r_pending ? r_req_addr : r_pc;
                if (branch_valid && w_req && !imem_ack)
                    w_state_nxt = FLUSH;
            end
            FLUSH: begin
                w_req  = rst_n;
                w_addr = r_req_addr;
                if (imem_ack)
                    w_state_nxt = FETCH;
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_pending  <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_pc_plus8 <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_req && !imem_ack;
            if (w_req)
                r_req_addr <= w_addr;

            // Branch wins: any ack in the same cycle, or in FLUSH, is dropped.
            if (branch_valid) begin
                r_pc    <= w_target;
                r_valid <= 1'b0;
            end else if (r_state == FETCH && w_fire) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
                r_pc_plus8 <= r_pc + ADDR_W'(PC_READ_OFFSET);
                r_valid    <= 1'b1;
                r_pc       <= r_pc + ADDR_W'(INSTR_BYTES);
            end else if (r_valid && !stall) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign pc_plus8    = r_pc_plus8;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus pushes expected fetches,
// negedge monitors pop and compare every instruction decode consumes.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, branch_valid;
    logic [31:0] branch_target;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid;
    logic [31:0] instr, instr_pc, pc_plus8;

    logic        rst2_n;
    logic        s_zero = 1'b0;
    logic [31:0] z_target = 32'h0;
    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2, pc8_2;

    int ws;
    int wcnt;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_010C) return 32'hE3A0_1005;
        return ~a;
    endfunction

    // Memory model: ack after ws wait cycles, rdata combinational on address.
    assign imem_ack   = imem_req && (wcnt >= ws);
    assign imem_rdata = mem(imem_addr);
    always @(posedge clk)
        if (!rst_n || !imem_req || imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;

    assign ack2   = req2;
    assign rdata2 = mem(addr2);

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8)
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .stall(s_zero), .branch_valid(s_zero), .branch_target(z_target),
        .instr_valid(valid2), .instr(instr2), .instr_pc(pc2), .pc_plus8(pc8_2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pc8);
        q.push_back({mem(pc), pc, pc8});
    endtask

    task automatic push2(input logic [31:0] pc, input logic [31:0] pc8);
        q2.push_back({mem(pc), pc, pc8});
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n === 1'b1 && instr_valid === 1'b1 && stall === 1'b0) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut_unexpected instr_pc actual=%h expected=none", instr_pc);
            end else begin
                e = q.pop_front();
                chk("dut_instr", instr, e.instr);
                chk("dut_instr_pc", instr_pc, e.pc);
                chk("dut_pc_plus8", pc_plus8, e.pc8);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst2_n === 1'b1 && valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL wrap_unexpected instr_pc actual=%h expected=none", pc2);
            end else begin
                e = q2.pop_front();
                chk("wrap_instr", instr2, e.instr);
                chk("wrap_instr_pc", pc2, e.pc);
                chk("wrap_pc_plus8", pc8_2, e.pc8);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input bit second, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if ((second ? q2.size() : q.size()) == 0) done = 1'b1;
            else tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=pending expected=drained", name);
            if (second) q2.delete(); else q.delete();
        end
    endtask

    task automatic do_reset(input int w);
        rst_n = 1'b0; stall = 1'b0; branch_valid = 1'b0; ws = w;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        branch_target = 32'h0; ws = 0;
        tick(); tick();

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_pc_plus8", pc_plus8, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);

        // Zero-wait sequential fetch from RESET_PC
        push(32'h100, 32'h108); push(32'h104, 32'h10C); push(32'h108, 32'h110);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (instr_valid && instr_pc == 32'h10C) found = 1'b1;
        end
        chk("reach_10c", {31'b0, found}, 32'h1);

        // Stall three cycles on 0x10C
        stall = 1'b1;
        push(32'h10C, 32'h114); push(32'h110, 32'h118);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", {31'b0, imem_req}, 32'h0);
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
            chk("stall_instr", instr, 32'hE3A0_1005);
            chk("stall_instr_pc", instr_pc, 32'h10C);
            chk("stall_pc_plus8", pc_plus8, 32'h114);
            tick();
        end
        stall = 1'b0;
        wait_empty(1'b0, "stall_drain");

        // Branch while a 2-wait fetch of 0x104 is outstanding
        do_reset(2);
        push(32'h100, 32'h108); push(32'h200, 32'h208);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req && imem_addr == 32'h104) found = 1'b1;
        end
        chk("req_104_seen", {31'b0, found}, 32'h1);
        tick();
        branch_valid = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        chk("br_req", {31'b0, imem_req}, 32'h1);
        chk("br_addr", imem_addr, 32'h104);
        chk("br_ack", {31'b0, imem_ack}, 32'h0);
        chk("br_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        chk("flush_req", {31'b0, imem_req}, 32'h1);
        chk("flush_addr", imem_addr, 32'h104);
        chk("flush_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        @(negedge clk);
        chk("redir_req", {31'b0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h200);
        chk("redir_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        wait_empty(1'b0, "branch_drain");

        // Branch to unaligned target coincident with ack
        do_reset(1);
        push(32'h3FC, 32'h404);
        tick();
        branch_valid = 1'b1; branch_target = 32'h3FF;
        @(negedge clk);
        chk("coinc_ack", {31'b0, imem_ack}, 32'h1);
        chk("coinc_addr", imem_addr, 32'h100);
        tick();
        branch_valid = 1'b0;
        @(negedge clk);
        chk("align_req", {31'b0, imem_req}, 32'h1);
        chk("align_addr", imem_addr, 32'h3FC);
        chk("align_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        wait_empty(1'b0, "coinc_drain");

        // Reset while a fetch is outstanding
        do_reset(3);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        tick();
        @(negedge clk);
        chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("midrst_instr_pc", instr_pc, 32'h0);
        push(32'h100, 32'h108);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_req", {31'b0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h100);
        tick();
        wait_empty(1'b0, "restart_drain");
        rst_n = 1'b0;

        // Address wrap on the second instance
        push2(32'hFFFF_FFFC, 32'h0000_0004); push2(32'h0000_0000, 32'h0000_0008);
        rst2_n = 1'b1;
        @(negedge clk);
        chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        tick();
        wait_empty(1'b1, "wrap_drain");
        rst2_n = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
